// File: rtl/regfile_bypass.sv
// 32-entry register file: two combinational read ports, one write port, a hardwired
// zero register and optional same-cycle write-to-read forwarding.
module regfile_bypass #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] entry [NUM_REGS];

    // One enabled storage word per entry; the zero register has no storage at all.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == ZERO_REG) begin : g_zero
                assign entry[gi] = '0;
            end else begin : g_word
                logic             wr_sel;
                logic [WIDTH-1:0] word_d;
                logic [WIDTH-1:0] word_q;

                always_comb begin
                    wr_sel = RegWrite && (WriteRegister == ADDR_W'(gi));
                    word_d = wr_sel ? WriteData : word_q;
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        word_q <= '0;
                    end else begin
                        word_q <= word_d;
                    end
                end

                assign entry[gi] = word_q;
            end
        end
    endgenerate

    // Zero register and reset override forwarding, so those reads never see WriteData.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [WIDTH-1:0]  wr_data,
        input logic              rst_n
    );
        logic [WIDTH-1:0] data;
        data = stored;
        if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
        if ((addr == ZERO_ADDR) || !rst_n) begin
            data = '0;
        end
        return data;
    endfunction

    assign ReadData1 = read_port(ReadRegister1, entry[ReadRegister1], RegWrite,
                                 WriteRegister, WriteData, reset);
    assign ReadData2 = read_port(ReadRegister2, entry[ReadRegister2], RegWrite,
                                 WriteRegister, WriteData, reset);

endmodule
